// File: rtl/kbd_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the PS/2 keyboard controller:
//   - register addresses for the bus-visible register file
//   - bit positions inside the STATUS register
//   - the PS/2 frame receiver state enumeration
// ---------------------------------------------------------------------------
package kbd_pkg;

    localparam logic [7:0] ADDR_STATUS   = 8'h00;
    localparam logic [7:0] ADDR_SCANCODE = 8'h01;

    localparam int STAT_AVAIL_BIT     = 0;
    localparam int STAT_OVERFLOW_BIT  = 1;
    localparam int STAT_FRAME_ERR_BIT = 2;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver.
//   clk_i, rst_ni   : system clock, asynchronous active-low reset
//   ps2_clk_i       : raw PS/2 clock from the keyboard (asynchronous)
//   ps2_din_i       : raw PS/2 data from the keyboard (asynchronous)
//   byte_o          : last correctly received scan code
//   byte_valid_o    : one-cycle pulse, byte_o holds a new code
//   frame_err_o     : one-cycle pulse, a frame was rejected or timed out
// Both PS/2 lines are synchronized, the clock is glitch-filtered, and the
// frame FSM samples data on each falling edge of the filtered clock.
// ---------------------------------------------------------------------------
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_din_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]        clkSync_q;
    logic [1:0]        dinSync_q;
    logic              filtClk_q, filtClk_d;
    logic [FCNT_W-1:0] filtCnt_q, filtCnt_d;
    logic              fallEdge;
    logic              dataBit;

    rx_state_e         state_q, state_d;
    logic [2:0]        bitCnt_q, bitCnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parOk_q, parOk_d;
    logic [TO_W-1:0]   toCnt_q, toCnt_d;
    logic [7:0]        byte_q, byte_d;
    logic              byteValid_q, byteValid_d;
    logic              frameErr_q, frameErr_d;

    assign dataBit = dinSync_q[1];

    // Two-stage synchronizers; both lines reset to the idle-high level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkSync_q <= 2'b11;
            dinSync_q <= 2'b11;
        end else begin
            clkSync_q <= {clkSync_q[0], ps2_clk_i};
            dinSync_q <= {dinSync_q[0], ps2_din_i};
        end
    end

    // Clock filter: the filtered level flips only once FILTER_LEN consecutive
    // synchronized samples disagree with it. The falling edge is flagged in
    // the same cycle the filtered level drops so the FSM samples data there.
    always_comb begin
        filtClk_d = filtClk_q;
        filtCnt_d = '0;
        fallEdge  = 1'b0;
        if (clkSync_q[1] != filtClk_q) begin
            if (filtCnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filtClk_d = clkSync_q[1];
                fallEdge  = filtClk_q;
            end else begin
                filtCnt_d = filtCnt_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filtClk_q <= 1'b1;
            filtCnt_q <= '0;
        end else begin
            filtClk_q <= filtClk_d;
            filtCnt_q <= filtCnt_d;
        end
    end

    // Frame FSM with mid-frame inactivity timeout. Parity is checked when the
    // parity bit arrives and remembered until the stop bit decides the frame.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parOk_d     = parOk_q;
        byte_d      = byte_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;

        if (state_q == RX_IDLE || fallEdge) begin
            toCnt_d = '0;
        end else begin
            toCnt_d = toCnt_q + TO_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (fallEdge && !dataBit) begin
                    state_d  = RX_DATA;
                    bitCnt_d = 3'd0;
                end
            end
            RX_DATA: begin
                if (fallEdge) begin
                    shift_d  = {dataBit, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (fallEdge) begin
                    parOk_d = (^shift_q) ^ dataBit;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fallEdge) begin
                    state_d = RX_IDLE;
                    if (parOk_q && dataBit) begin
                        byte_d      = shift_q;
                        byteValid_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // A stalled keyboard mid-frame abandons the partial byte.
        if (state_q != RX_IDLE && !fallEdge && toCnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_d    = RX_IDLE;
            toCnt_d    = '0;
            frameErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RX_IDLE;
            bitCnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            parOk_q     <= 1'b0;
            toCnt_q     <= '0;
            byte_q      <= 8'h00;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parOk_q     <= parOk_d;
            toCnt_q     <= toCnt_d;
            byte_q      <= byte_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byteValid_q;
    assign frame_err_o  = frameErr_q;

endmodule

// File: rtl/keyboard_controller.sv
// ---------------------------------------------------------------------------
// keyboard_controller
// PS/2 keyboard interface with a scan-code FIFO and a small read-only
// register file.
//   clk_i, rst_ni : system clock, asynchronous active-low reset
//   en_i          : bus read enable
//   addr_i        : register address (0x00 STATUS, 0x01 SCANCODE)
//   dout_o        : registered read data, one clock latency
//   ps2_clk_i     : PS/2 clock from keyboard (asynchronous)
//   ps2_din_i     : PS/2 data from keyboard (asynchronous)
// Reading SCANCODE pops one entry per access; reading STATUS clears the
// sticky overflow and frame-error flags.
// ---------------------------------------------------------------------------
module keyboard_controller
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [7:0] addr_i,
    output logic [7:0] dout_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_din_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       rxByte;
    logic             rxValid;
    logic             rxErr;

    logic [7:0]       fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             frameErr_q, frameErr_d;
    logic             prevEn_q;
    logic [7:0]       prevAddr_q;
    logic [7:0]       dout_q, dout_d;

    logic             fifoEmpty, fifoFull;
    logic             accessStart, popReq, pushOk, clearFlags;
    logic [7:0]       headByte;
    logic [7:0]       statusReg;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ps2_rx (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_din_i   (ps2_din_i),
        .byte_o      (rxByte),
        .byte_valid_o(rxValid),
        .frame_err_o (rxErr)
    );

    // FIFO bookkeeping, access detection and the read mux. A held en_i/addr_i
    // pair is a single access, so side effects fire only on its first cycle.
    // When full, a push still succeeds if the same cycle pops.
    always_comb begin
        fifoEmpty   = (count_q == '0);
        fifoFull    = (count_q == CNT_W'(FIFO_DEPTH));
        accessStart = en_i && (!prevEn_q || addr_i != prevAddr_q);
        popReq      = accessStart && addr_i == ADDR_SCANCODE && !fifoEmpty;
        pushOk      = rxValid && (!fifoFull || popReq);
        clearFlags  = accessStart && addr_i == ADDR_STATUS;

        headByte  = fifoEmpty ? 8'h00 : fifoMem_q[rdPtr_q];
        statusReg = 8'h00;
        statusReg[STAT_AVAIL_BIT]     = !fifoEmpty;
        statusReg[STAT_OVERFLOW_BIT]  = overflow_q;
        statusReg[STAT_FRAME_ERR_BIT] = frameErr_q;

        wrPtr_d = pushOk ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = popReq ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d = count_q;
        if (pushOk && !popReq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!pushOk && popReq) begin
            count_d = count_q - CNT_W'(1);
        end

        // A new event in the clearing cycle keeps its flag set.
        overflow_d = (rxValid && fifoFull && !popReq) || (overflow_q && !clearFlags);
        frameErr_d = rxErr || (frameErr_q && !clearFlags);

        dout_d = 8'h00;
        if (en_i) begin
            case (addr_i)
                ADDR_STATUS:   dout_d = statusReg;
                ADDR_SCANCODE: dout_d = headByte;
                default:       dout_d = 8'h00;
            endcase
        end
    end

    // Control state and registered read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            frameErr_q <= 1'b0;
            prevEn_q   <= 1'b0;
            prevAddr_q <= 8'h00;
            dout_q     <= 8'h00;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            frameErr_q <= frameErr_d;
            prevEn_q   <= en_i;
            prevAddr_q <= addr_i;
            dout_q     <= dout_d;
        end
    end

    // FIFO storage needs no reset; only entries covered by count are visible.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            fifoMem_q[wrPtr_q] <= rxByte;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: tb/tb_keyboard_controller.sv
// ---------------------------------------------------------------------------
// tb_keyboard_controller
// Self-checking bench for keyboard_controller. The keyboard side is a
// bit-level PS/2 frame generator; expected register contents come from a
// queue-based model of the scan-code buffer and its two sticky flags.
// ---------------------------------------------------------------------------
module tb_keyboard_controller;

    localparam int DEPTH   = 16;
    localparam int HALF    = 20;
    localparam int TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       rstN;
    logic       en;
    logic [7:0] addr;
    logic [7:0] dout;
    logic       ps2Clk;
    logic       ps2Din;

    int checks = 0;
    int errors = 0;

    logic [7:0] modelQ[$];
    bit         modelOvf;
    bit         modelFerr;

    always #5 clk = ~clk;

    keyboard_controller #(
        .FIFO_DEPTH (DEPTH),
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .en_i     (en),
        .addr_i   (addr),
        .dout_o   (dout),
        .ps2_clk_i(ps2Clk),
        .ps2_din_i(ps2Din)
    );

    // Watchdog so the run always ends even if the bench stalls.
    initial begin
        #800us;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 800us");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model: a completed frame either lands in the buffer, overflows, or is a frame error.
    function automatic void modelReceive(input logic [7:0] code, input bit good);
        if (!good) begin
            modelFerr = 1'b1;
        end else if (modelQ.size() < DEPTH) begin
            modelQ.push_back(code);
        end else begin
            modelOvf = 1'b1;
        end
    endfunction

    // Model: the value returned by a fresh read access, with its side effects.
    function automatic logic [7:0] modelRead(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (a == 8'h00) begin
            v = {5'b0, modelFerr, modelOvf, modelQ.size() != 0};
            modelOvf  = 1'b0;
            modelFerr = 1'b0;
        end else if (a == 8'h01) begin
            if (modelQ.size() != 0) v = modelQ.pop_front();
        end
        return v;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic ps2Bit(input logic b);
        ps2Din = b;
        waitCycles(HALF);
        ps2Clk = 1'b0;
        waitCycles(HALF);
        ps2Clk = 1'b1;
    endtask

    // Sends one complete frame and records its expected effect in the model.
    task automatic applyStimulus(input logic [7:0] code, input bit goodParity, input bit goodStop);
        logic par;
        par = ~^code;
        if (!goodParity) par = ~par;
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(code[i]);
        ps2Bit(par);
        ps2Bit(goodStop);
        ps2Din = 1'b1;
        waitCycles(HALF);
        modelReceive(code, goodParity && goodStop);
    endtask

    // One single-cycle read access followed by an idle cycle.
    task automatic readReg(input logic [7:0] a, input string tag);
        logic [7:0] exp;
        exp  = modelRead(a);
        en   = 1'b1;
        addr = a;
        @(negedge clk);
        checkOutput(tag, dout, exp);
        en = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] exp;
    logic [7:0] seqCodes [6];
    logic [7:0] rndCode;
    bit         rndGood;

    initial begin
        rstN   = 1'b0;
        en     = 1'b0;
        addr   = 8'h00;
        ps2Clk = 1'b1;
        ps2Din = 1'b1;
        modelOvf  = 1'b0;
        modelFerr = 1'b0;
        waitCycles(3);
        checkOutput("reset_dout", dout, 8'h00);
        rstN = 1'b1;
        waitCycles(3);

        // Empty-buffer reads must not underflow.
        readReg(8'h00, "idle_status");
        readReg(8'h01, "empty_scancode");
        readReg(8'h00, "status_after_empty_pop");
        readReg(8'h05, "unmapped_addr");

        // Held STATUS then held SCANCODE: one access each, exactly one pop.
        applyStimulus(8'h1C, 1, 1);
        applyStimulus(8'hF0, 1, 1);
        applyStimulus(8'h1C, 1, 1);
        exp  = modelRead(8'h00);
        en   = 1'b1;
        addr = 8'h00;
        @(negedge clk);
        checkOutput("hold_status_c1", dout, exp);
        @(negedge clk);
        checkOutput("hold_status_c2", dout, exp);
        exp  = modelRead(8'h01);
        addr = 8'h01;
        @(negedge clk);
        checkOutput("hold_scan_c1", dout, exp);
        @(negedge clk);
        checkOutput("hold_scan_c2_head", dout, modelQ[0]);
        en = 1'b0;
        @(negedge clk);
        checkOutput("en_low_dout", dout, 8'h00);
        readReg(8'h01, "after_hold_1");
        readReg(8'h01, "after_hold_2");
        readReg(8'h00, "after_hold_status");

        // Raw make/break sequence delivered in order.
        seqCodes = '{8'h12, 8'h32, 8'hF0, 8'h32, 8'hF0, 8'h12};
        foreach (seqCodes[i]) applyStimulus(seqCodes[i], 1, 1);
        for (int i = 0; i < 6; i++) readReg(8'h01, "seq_read");
        readReg(8'h00, "seq_status");

        // Parity error, then stop-bit error.
        applyStimulus(8'h1C, 0, 1);
        readReg(8'h00, "parity_err_status");
        readReg(8'h00, "parity_err_cleared");
        applyStimulus(8'h5A, 1, 0);
        readReg(8'h00, "stop_err_status");
        readReg(8'h01, "stop_err_no_entry");

        // Overflow: seventeen codes with nothing read.
        for (int i = 0; i < 17; i++) applyStimulus(8'h20 + 8'(i), 1, 1);
        readReg(8'h00, "overflow_status");
        for (int i = 0; i < 16; i++) readReg(8'h01, "overflow_drain");
        readReg(8'h00, "overflow_cleared");

        // Keyboard stalls after four data bits, then a good frame follows.
        ps2Bit(1'b0);
        for (int i = 0; i < 4; i++) ps2Bit(1'b1);
        ps2Din = 1'b1;
        waitCycles(TIMEOUT + 100);
        modelFerr = 1'b1;
        applyStimulus(8'h32, 1, 1);
        readReg(8'h00, "timeout_status");
        readReg(8'h01, "timeout_next_code");

        // Reset in the middle of a frame with two codes queued.
        applyStimulus(8'h11, 1, 1);
        applyStimulus(8'h22, 1, 1);
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b0);
        exp  = modelRead(8'h00);
        en   = 1'b1;
        addr = 8'h00;
        @(negedge clk);
        checkOutput("pre_reset_status", dout, exp);
        rstN = 1'b0;
        #1;
        checkOutput("async_reset_dout", dout, 8'h00);
        modelQ.delete();
        modelOvf  = 1'b0;
        modelFerr = 1'b0;
        en     = 1'b0;
        ps2Clk = 1'b1;
        ps2Din = 1'b1;
        waitCycles(4);
        rstN = 1'b1;
        waitCycles(4);
        readReg(8'h00, "post_reset_status");
        applyStimulus(8'h1C, 1, 1);
        readReg(8'h01, "post_reset_code");

        // Random traffic against the model, including errors and overflow.
        for (int n = 0; n < 30; n++) begin
            rndCode = 8'($urandom);
            rndGood = ($urandom_range(0, 5) != 0);
            applyStimulus(rndCode, rndGood, 1);
            for (int r = 0; r < int'($urandom_range(0, 2)); r++) begin
                case ($urandom_range(0, 3))
                    0:       readReg(8'h00, "rnd_status");
                    3:       readReg(8'($urandom_range(2, 255)), "rnd_unmapped");
                    default: readReg(8'h01, "rnd_scancode");
                endcase
            end
        end
        readReg(8'h00, "rnd_final_status");
        while (modelQ.size() != 0) readReg(8'h01, "rnd_drain");
        readReg(8'h00, "rnd_drained_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
